dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Data-memory controller between the core's data-memory port and a single-port, word-organised data RAM with variable-latency request/acknowledge handshake. It aligns store data and byte enables to the addressed lanes. It extracts and sign- or zero-extends load data, and stalls the core until the RAM acknowledges. Misaligned accesses are rejected without touching the RAM and are flagged to the core.

## Interface
Parameters:
- `XLEN`, 32, data width; only 32 is supported.
- `DMEM_WIDTH`, 12, byte-address width of the core port; RAM word address is `DMEM_WIDTH-2` bits.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `rden_dmem` in 1: load request from the core.
- `wren_dmem` in 1: store request from the core.
- `dmem_addr` in `DMEM_WIDTH`: byte address.
- `dmem_data_in` in 32: store data, low-aligned.
- `mem_byte_mem` in 4: access size as a low-aligned mask. `0001` is byte, `0011` is half, `1111` is word. Other codes are treated as word.
- `load_unsigned` in 1: 1 selects zero-extension of load data, 0 selects sign-extension.
- `dmem_data_out` out 32: formatted load result.
- `dmem_stall` out 1: core must hold the request and all request inputs stable while this is high.
- `misaligned_err` out 1: one-cycle pulse for a rejected access.
- `ram_req` out 1, `ram_we` out 1, `ram_addr` out `DMEM_WIDTH-2`, `ram_be` out 4, `ram_wdata` out 32: RAM request side.
- `ram_ack` in 1, `ram_rdata` in 32: RAM response side. `ram_rdata` is valid in the `ram_ack` cycle.

## Operation
- FSM states:
  - IDLE: an aligned request goes to REQ; the fields are captured into registers.
  - REQ: `ram_req`=1, all RAM outputs held constant; `ram_ack` moves the FSM to DONE.
  - DONE: always returns to IDLE; core request inputs are ignored in this cycle.
- Request: `rden_dmem | wren_dmem`. If both are high, the access is a store.
- Alignment: a half access is misaligned when `addr[0]`=1. A word access is misaligned when `addr[1:0]`≠0.
- Misaligned request in IDLE:
  - `misaligned_err` pulses on the next cycle.
  - No RAM access, no stall, state stays IDLE.
  - `dmem_data_out` is unchanged.
- Stores:
  - `ram_be` = size mask << `addr[1:0]`.
  - `ram_wdata` = `dmem_data_in` << (8·`addr[1:0]`).
  - `ram_we`=1.
- Loads:
  - `ram_be`=`1111`, `ram_we`=0.
  - On ack, the selected lane(s) are extracted from `ram_rdata` >> (8·`addr[1:0]`).
  - The extracted value is extended per captured size and `load_unsigned`, then registered into `dmem_data_out`.
- `dmem_data_out` holds its value until the next load completes. Stores do not modify it.
- `dmem_stall` is combinational. It is 1 when (IDLE and aligned request) or state is REQ, and 0 otherwise.

## Timing
- Reset values: state IDLE; `ram_req`, `ram_we`, `ram_be`, `ram_addr`, `ram_wdata` all 0; `dmem_data_out`=0; `misaligned_err`=0; `dmem_stall`=0 when no request is present.
- Request cycle and RAM cycles:
  - Request accepted in cycle 0: `ram_req` rises at cycle 1 and stays high through the ack cycle inclusive.
  - Ack in cycle k (k≥1): `ram_req` is low at cycle k+1, state is DONE, and load data is valid on `dmem_data_out` from cycle k+1.
- Stall and latency:
  - `dmem_stall` is high for cycles 0..k and low in k+1, where the core advances.
  - Minimum load latency is 2 cycles, reached with an ack in the same cycle `ram_req` rises.
- `ram_ack` while not in REQ is ignored.
- Back-to-back accesses: the next request is accepted in IDLE, at the earliest cycle k+2.
- `rst` mid-access:
  - IDLE and `ram_req`=0 at the next edge.
  - Any later `ram_ack` for the aborted access is ignored.
  - `dmem_data_out` is cleared to 0.

## Test plan
- Word store, addr `0x010`, data `0xDEADBEEF`, ack at cycle 1:
  - Required: `ram_addr`=`0x004`, `ram_be`=`1111`, `ram_wdata`=`0xDEADBEEF`, `ram_we`=1.
  - Required: stall high for cycles 0–1 and low at 2.
- Byte store, addr `0x013`, data `0x000000A5`: `ram_be`=`1000`, `ram_wdata`=`0xA5000000`.
- Loads from `ram_rdata`=`0x80F17F02`:
  - Byte signed at `0x001`: `dmem_data_out`=`0x0000007F`.
  - Byte signed at `0x003`: `0xFFFFFF80`.
  - Half unsigned at `0x002`: `0x000080F1`.
  - Half signed at `0x002`: `0xFFFF80F1`.
- Word load with ack delayed 5 cycles after `ram_req`:
  - Required: `ram_req` and all RAM outputs stable for 6 cycles, stall high 7 cycles.
  - Required: data appears the cycle after ack, and a spurious ack in IDLE is ignored.
- Misaligned word load at `0x006`:
  - Required: `misaligned_err` pulses once, `ram_req` stays 0, no stall, `dmem_data_out` unchanged.
- `rst` asserted while in REQ, with ack arriving after reset:
  - Required: state IDLE, `ram_req`=0, `dmem_data_out`=0.
  - Required: a new store is then accepted normally.

Source files
------------

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller from the core port to a word RAM
// with a variable-latency req/ack handshake.
// Ports:
//   core in : clk, rst, rden_dmem, wren_dmem, dmem_addr,
//             dmem_data_in, mem_byte_mem, load_unsigned
//   core out: dmem_data_out, dmem_stall, misaligned_err
//   ram out : ram_req, ram_we, ram_addr, ram_be, ram_wdata
//   ram in  : ram_ack, ram_rdata
module dmem_ctrl #(
  parameter int XLEN       = 32,
  parameter int DMEM_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rden_dmem,
  input  logic                  wren_dmem,
  input  logic [DMEM_WIDTH-1:0] dmem_addr,
  input  logic [XLEN-1:0]       dmem_data_in,
  input  logic [3:0]            mem_byte_mem,
  input  logic                  load_unsigned,
  output logic [XLEN-1:0]       dmem_data_out,
  output logic                  dmem_stall,
  output logic                  misaligned_err,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [DMEM_WIDTH-3:0] ram_addr,
  output logic [3:0]            ram_be,
  output logic [XLEN-1:0]       ram_wdata,
  input  logic                  ram_ack,
  input  logic [XLEN-1:0]       ram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  state_e                state_q;
  size_e                 size_d;
  size_e                 size_q;
  logic [1:0]            off_d;
  logic [1:0]            off_q;
  logic                  uns_q;

  logic                  req_d;
  logic                  store_d;
  logic                  misal_d;
  logic                  accept_d;
  logic                  reject_d;
  logic [3:0]            mask_d;
  logic [3:0]            be_d;
  logic [XLEN-1:0]       wdata_d;
  logic [XLEN-1:0]       shift_d;
  logic [XLEN-1:0]       load_d;

  logic                  ram_req_q;
  logic                  ram_we_q;
  logic [DMEM_WIDTH-3:0] ram_addr_q;
  logic [3:0]            ram_be_q;
  logic [XLEN-1:0]       ram_wdata_q;
  logic [XLEN-1:0]       data_q;
  logic                  err_q;

  assign req_d   = rden_dmem | wren_dmem;
  assign store_d = wren_dmem;
  assign off_d   = dmem_addr[1:0];

  // Unknown size codes fall back to a full word.
  always_comb begin
    size_d = SZ_W;
    mask_d = 4'b1111;
    case (mem_byte_mem)
      4'b0001: begin
        size_d = SZ_B;
        mask_d = 4'b0001;
      end
      4'b0011: begin
        size_d = SZ_H;
        mask_d = 4'b0011;
      end
      default: begin
        size_d = SZ_W;
        mask_d = 4'b1111;
      end
    endcase
  end

  always_comb begin
    misal_d = 1'b0;
    unique case (1'b1)
      (size_d == SZ_H): misal_d = off_d[0];
      (size_d == SZ_W): misal_d = (off_d != 2'b00);
      default:          misal_d = 1'b0;
    endcase
  end

  assign accept_d = (state_q == S_IDLE) & req_d & ~misal_d;
  assign reject_d = (state_q == S_IDLE) & req_d & misal_d;

  // Loads always fetch the whole word; lane pick happens on return.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = '0;
    if (store_d) begin
      be_d    = mask_d << off_d;
      wdata_d = dmem_data_in << {off_d, 3'b000};
    end
  end

  always_comb begin
    shift_d = ram_rdata >> {off_q, 3'b000};
    load_d  = shift_d;
    case (size_q)
      SZ_B: load_d = {{(XLEN-8){~uns_q & shift_d[7]}},
                      shift_d[7:0]};
      SZ_H: load_d = {{(XLEN-16){~uns_q & shift_d[15]}},
                      shift_d[15:0]};
      default: load_d = shift_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      size_q      <= SZ_W;
      off_q       <= 2'b00;
      uns_q       <= 1'b0;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_be_q    <= 4'b0000;
      ram_wdata_q <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= reject_d;
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            state_q     <= S_REQ;
            ram_req_q   <= 1'b1;
            ram_we_q    <= store_d;
            ram_addr_q  <= dmem_addr[DMEM_WIDTH-1:2];
            ram_be_q    <= be_d;
            ram_wdata_q <= wdata_d;
            size_q      <= size_d;
            off_q       <= off_d;
            uns_q       <= load_unsigned;
          end
        end
        S_REQ: begin
          if (ram_ack) begin
            state_q   <= S_DONE;
            ram_req_q <= 1'b0;
            if (!ram_we_q) begin
              data_q <= load_d;
            end
          end
        end
        S_DONE: begin
          // Core advances this cycle; its inputs are not yet valid.
          state_q <= S_IDLE;
        end
        default: begin
          state_q   <= S_IDLE;
          ram_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign dmem_stall     = accept_d | (state_q == S_REQ);
  assign misaligned_err = err_q;
  assign dmem_data_out  = data_q;
  assign ram_req        = ram_req_q;
  assign ram_we         = ram_we_q;
  assign ram_addr       = ram_addr_q;
  assign ram_be         = ram_be_q;
  assign ram_wdata      = ram_wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: scoreboard bench for dmem_ctrl.
// Ports: none; drives core and RAM sides, compares both.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rden_dmem = 1'b0;
  logic        wren_dmem = 1'b0;
  logic [11:0] dmem_addr = '0;
  logic [31:0] dmem_data_in = '0;
  logic [3:0]  mem_byte_mem = 4'b1111;
  logic        load_unsigned = 1'b0;
  logic [31:0] dmem_data_out;
  logic        dmem_stall;
  logic        misaligned_err;
  logic        ram_req;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic        ram_ack = 1'b0;
  logic [31:0] ram_rdata = '0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [11:0] a;
    logic [31:0] wd;
    logic [3:0]  sz;
    bit          uns;
    int          dly;
    logic [31:0] rdat;
  } stim_t;

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ld;
    int          stall_n;
    int          req_n;
  } exp_t;

  stim_t st_q[$];
  exp_t  exp_q[$];

  logic [31:0] model_out = '0;

  logic        obs_we;
  logic [9:0]  obs_addr;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata;
  logic [31:0] obs_ld;
  logic        obs_stable;
  logic        obs_req0;
  logic        obs_req_after;
  int          obs_stall_n;
  int          obs_req_n;

  dmem_ctrl #(.XLEN(32), .DMEM_WIDTH(12)) dut (
    .clk           (clk),
    .rst           (rst),
    .rden_dmem     (rden_dmem),
    .wren_dmem     (wren_dmem),
    .dmem_addr     (dmem_addr),
    .dmem_data_in  (dmem_data_in),
    .mem_byte_mem  (mem_byte_mem),
    .load_unsigned (load_unsigned),
    .dmem_data_out (dmem_data_out),
    .dmem_stall    (dmem_stall),
    .misaligned_err(misaligned_err),
    .ram_req       (ram_req),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_be        (ram_be),
    .ram_wdata     (ram_wdata),
    .ram_ack       (ram_ack),
    .ram_rdata     (ram_rdata)
  );

  always #5 clk = ~clk;

  task automatic add_vec(
    input bit          wr,
    input bit          rd,
    input logic [11:0] a,
    input logic [31:0] wd,
    input logic [3:0]  sz,
    input bit          uns,
    input int          dly,
    input logic [31:0] rdat,
    input logic [9:0]  ea,
    input logic [3:0]  ebe,
    input logic [31:0] ewd,
    input logic [31:0] eld
  );
    stim_t s;
    exp_t  e;
    s = '{wr: wr, rd: rd, a: a, wd: wd, sz: sz,
          uns: uns, dly: dly, rdat: rdat};
    e = '{we: wr, addr: ea, be: ebe, wdata: ewd,
          ld: eld, stall_n: dly + 2, req_n: dly + 1};
    st_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // One access from request (cycle 0) through the DONE cycle.
  task automatic drive_access(input stim_t s);
    @(posedge clk); #1;
    wren_dmem     = s.wr;
    rden_dmem     = s.rd;
    dmem_addr     = s.a;
    dmem_data_in  = s.wd;
    mem_byte_mem  = s.sz;
    load_unsigned = s.uns;
    ram_ack       = 1'b0;
    obs_stall_n   = 0;
    obs_req_n     = 0;
    obs_stable    = 1'b1;
    @(negedge clk);
    if (dmem_stall) obs_stall_n++;
    obs_req0 = ram_req;
    for (int c = 1; c <= s.dly + 1; c++) begin
      @(posedge clk); #1;
      ram_ack   = (c == s.dly + 1);
      ram_rdata = (c == s.dly + 1) ? s.rdat : $urandom;
      @(negedge clk);
      if (dmem_stall) obs_stall_n++;
      if (ram_req) obs_req_n++;
      if (c == 1) begin
        obs_we    = ram_we;
        obs_addr  = ram_addr;
        obs_be    = ram_be;
        obs_wdata = ram_wdata;
      end else if ({ram_we, ram_addr, ram_be, ram_wdata} !==
                   {obs_we, obs_addr, obs_be, obs_wdata}) begin
        obs_stable = 1'b0;
      end
    end
    @(posedge clk); #1;
    ram_ack   = 1'b0;
    rden_dmem = 1'b0;
    wren_dmem = 1'b0;
    ram_rdata = $urandom;
    @(negedge clk);
    if (dmem_stall) obs_stall_n++;
    obs_req_after = ram_req;
    obs_ld        = dmem_data_out;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({ram_req, ram_we, ram_be} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctl: got %b want 000000",
               {ram_req, ram_we, ram_be});
    end
    tests++;
    if ({ram_addr, ram_wdata} !== 42'b0) begin
      fails++;
      $display("FAIL reset_addr_wdata: got %h/%h want 0/0",
               ram_addr, ram_wdata);
    end
    tests++;
    if (dmem_data_out !== 32'h0) begin
      fails++;
      $display("FAIL reset_dout: got %h want 0", dmem_data_out);
    end
    tests++;
    if ({misaligned_err, dmem_stall} !== 2'b00) begin
      fails++;
      $display("FAIL reset_err_stall: got %b want 00",
               {misaligned_err, dmem_stall});
    end
    model_out = 32'h0;
  endtask

  task automatic test_store();
    stim_t s;
    exp_t  e;
    add_vec(1, 0, 12'h010, 32'hDEADBEEF, 4'b1111, 0, 0, 32'h0,
            10'h004, 4'b1111, 32'hDEADBEEF, model_out);
    add_vec(1, 0, 12'h013, 32'h000000A5, 4'b0001, 0, 0, 32'h0,
            10'h004, 4'b1000, 32'hA5000000, model_out);
    add_vec(1, 0, 12'h00E, 32'h00001234, 4'b0011, 0, 2, 32'h0,
            10'h003, 4'b1100, 32'h12340000, model_out);
    add_vec(1, 1, 12'h020, 32'h01020304, 4'b1111, 0, 1, 32'h0,
            10'h008, 4'b1111, 32'h01020304, model_out);
    add_vec(1, 0, 12'h024, 32'h0BADCAFE, 4'b0101, 0, 0, 32'h0,
            10'h009, 4'b1111, 32'h0BADCAFE, model_out);
    while (st_q.size() > 0) begin
      s = st_q.pop_front();
      drive_access(s);
      e = exp_q.pop_front();
      tests++;
      if ({obs_req0, obs_we} !== {1'b0, e.we}) begin
        fails++;
        $display("FAIL st_req0_we @%h: got %b want 0%b",
                 s.a, {obs_req0, obs_we}, e.we);
      end
      tests++;
      if ({obs_addr, obs_be} !== {e.addr, e.be}) begin
        fails++;
        $display("FAIL st_addr_be @%h: got %h/%b want %h/%b",
                 s.a, obs_addr, obs_be, e.addr, e.be);
      end
      tests++;
      if (obs_wdata !== e.wdata) begin
        fails++;
        $display("FAIL st_wdata @%h: got %h want %h",
                 s.a, obs_wdata, e.wdata);
      end
      tests++;
      if (obs_stall_n != e.stall_n || obs_req_n != e.req_n) begin
        fails++;
        $display("FAIL st_timing @%h: got %0d/%0d want %0d/%0d",
                 s.a, obs_stall_n, obs_req_n, e.stall_n, e.req_n);
      end
      tests++;
      if (obs_ld !== e.ld || obs_req_after !== 1'b0) begin
        fails++;
        $display("FAIL st_dout_hold @%h: got %h/%b want %h/0",
                 s.a, obs_ld, obs_req_after, e.ld);
      end
    end
  endtask

  task automatic test_load();
    stim_t s;
    exp_t  e;
    add_vec(0, 1, 12'h001, 32'h0, 4'b0001, 0, 0, 32'h80F17F02,
            10'h000, 4'b1111, 32'h0, 32'h0000007F);
    add_vec(0, 1, 12'h003, 32'h0, 4'b0001, 0, 1, 32'h80F17F02,
            10'h000, 4'b1111, 32'h0, 32'hFFFFFF80);
    add_vec(0, 1, 12'h002, 32'h0, 4'b0011, 1, 0, 32'h80F17F02,
            10'h000, 4'b1111, 32'h0, 32'h000080F1);
    add_vec(0, 1, 12'h002, 32'h0, 4'b0011, 0, 2, 32'h80F17F02,
            10'h000, 4'b1111, 32'h0, 32'hFFFF80F1);
    add_vec(0, 1, 12'h103, 32'h0, 4'b0001, 1, 0, 32'h80F17F02,
            10'h040, 4'b1111, 32'h0, 32'h00000080);
    add_vec(0, 1, 12'h000, 32'h0, 4'b0011, 0, 0, 32'h80F17F02,
            10'h000, 4'b1111, 32'h0, 32'h00007F02);
    add_vec(0, 1, 12'h004, 32'h0, 4'b0111, 0, 0, 32'h80F17F02,
            10'h001, 4'b1111, 32'h0, 32'h80F17F02);
    while (st_q.size() > 0) begin
      s = st_q.pop_front();
      drive_access(s);
      e = exp_q.pop_front();
      tests++;
      if ({obs_we, obs_addr, obs_be} !== {1'b0, e.addr, e.be}) begin
        fails++;
        $display("FAIL ld_req @%h: got %b/%h/%b want 0/%h/%b",
                 s.a, obs_we, obs_addr, obs_be, e.addr, e.be);
      end
      tests++;
      if (obs_stall_n != e.stall_n) begin
        fails++;
        $display("FAIL ld_stall @%h: got %0d want %0d",
                 s.a, obs_stall_n, e.stall_n);
      end
      tests++;
      if (obs_ld !== e.ld) begin
        fails++;
        $display("FAIL ld_data @%h sz %b u %0b: got %h want %h",
                 s.a, s.sz, s.uns, obs_ld, e.ld);
      end
      model_out = e.ld;
    end
  endtask

  task automatic test_long_ack();
    stim_t s;
    exp_t  e;
    add_vec(0, 1, 12'h0A4, 32'h0, 4'b1111, 0, 5, 32'hCAFEF00D,
            10'h029, 4'b1111, 32'h0, 32'hCAFEF00D);
    s = st_q.pop_front();
    drive_access(s);
    e = exp_q.pop_front();
    tests++;
    if (obs_stable !== 1'b1 || obs_addr !== e.addr) begin
      fails++;
      $display("FAIL long_stable: got %b/%h want 1/%h",
               obs_stable, obs_addr, e.addr);
    end
    tests++;
    if (obs_req_n != 6 || obs_stall_n != 7) begin
      fails++;
      $display("FAIL long_timing: got req %0d stall %0d want 6/7",
               obs_req_n, obs_stall_n);
    end
    tests++;
    if (obs_ld !== e.ld || obs_req_after !== 1'b0) begin
      fails++;
      $display("FAIL long_data: got %h/%b want %h/0",
               obs_ld, obs_req_after, e.ld);
    end
    model_out = e.ld;
    @(posedge clk); #1;
    ram_ack   = 1'b1;
    ram_rdata = 32'h11111111;
    @(negedge clk);
    tests++;
    if ({ram_req, dmem_stall} !== 2'b00) begin
      fails++;
      $display("FAIL spurious_ack_req: got %b want 00",
               {ram_req, dmem_stall});
    end
    @(posedge clk); #1;
    ram_ack = 1'b0;
    @(negedge clk);
    tests++;
    if (dmem_data_out !== model_out || ram_req !== 1'b0) begin
      fails++;
      $display("FAIL spurious_ack_data: got %h/%b want %h/0",
               dmem_data_out, ram_req, model_out);
    end
  endtask

  task automatic test_misaligned();
    logic [11:0] a;
    logic [3:0]  sz;
    bit          wr;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin a = 12'h006; sz = 4'b1111; wr = 0; end
        1:       begin a = 12'h003; sz = 4'b0011; wr = 0; end
        default: begin a = 12'h002; sz = 4'b1111; wr = 1; end
      endcase
      @(posedge clk); #1;
      rden_dmem    = ~wr;
      wren_dmem    = wr;
      dmem_addr    = a;
      mem_byte_mem = sz;
      dmem_data_in = 32'hFFFFFFFF;
      @(negedge clk);
      tests++;
      if ({dmem_stall, ram_req} !== 2'b00) begin
        fails++;
        $display("FAIL mis_nostall @%h: got %b want 00",
                 a, {dmem_stall, ram_req});
      end
      @(posedge clk); #1;
      rden_dmem = 1'b0;
      wren_dmem = 1'b0;
      @(negedge clk);
      tests++;
      if ({misaligned_err, ram_req} !== 2'b10 ||
          dmem_data_out !== model_out) begin
        fails++;
        $display("FAIL mis_pulse @%h: got %b/%h want 10/%h",
                 a, {misaligned_err, ram_req}, dmem_data_out,
                 model_out);
      end
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (misaligned_err !== 1'b0) begin
        fails++;
        $display("FAIL mis_once @%h: got %b want 0",
                 a, misaligned_err);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    exp_t  e;
    add_vec(0, 1, 12'h008, 32'h0, 4'b1111, 0, 0, 32'h13579BDF,
            10'h002, 4'b1111, 32'h0, 32'h13579BDF);
    add_vec(1, 0, 12'h009, 32'h000000EE, 4'b0001, 0, 0, 32'h0,
            10'h002, 4'b0010, 32'h0000EE00, 32'h13579BDF);
    add_vec(0, 1, 12'h00A, 32'h0, 4'b0001, 1, 0, 32'h00770000,
            10'h002, 4'b1111, 32'h0, 32'h00000077);
    while (st_q.size() > 0) begin
      s = st_q.pop_front();
      drive_access(s);
      e = exp_q.pop_front();
      tests++;
      if ({obs_we, obs_addr, obs_be} !== {e.we, e.addr, e.be}) begin
        fails++;
        $display("FAIL b2b_req @%h: got %b/%h/%b want %b/%h/%b",
                 s.a, obs_we, obs_addr, obs_be, e.we, e.addr, e.be);
      end
      tests++;
      if (obs_stall_n != e.stall_n) begin
        fails++;
        $display("FAIL b2b_stall @%h: got %0d want %0d",
                 s.a, obs_stall_n, e.stall_n);
      end
      tests++;
      if (obs_ld !== e.ld) begin
        fails++;
        $display("FAIL b2b_dout @%h: got %h want %h",
                 s.a, obs_ld, e.ld);
      end
      if (e.we) begin
        tests++;
        if (obs_wdata !== e.wdata) begin
          fails++;
          $display("FAIL b2b_wdata @%h: got %h want %h",
                   s.a, obs_wdata, e.wdata);
        end
      end
      model_out = e.ld;
    end
  endtask

  task automatic test_rst_mid();
    stim_t s;
    exp_t  e;
    @(posedge clk); #1;
    rden_dmem    = 1'b1;
    dmem_addr    = 12'h000;
    mem_byte_mem = 4'b1111;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (ram_req !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_inreq: got %b want 1", ram_req);
    end
    @(posedge clk); #1;
    rst       = 1'b1;
    rden_dmem = 1'b0;
    @(posedge clk); #1;
    rst       = 1'b0;
    ram_ack   = 1'b1;
    ram_rdata = 32'h12345678;
    @(negedge clk);
    tests++;
    if ({ram_req, dmem_stall} !== 2'b00 ||
        dmem_data_out !== 32'h0) begin
      fails++;
      $display("FAIL rst_mid_clear: got %b/%h want 00/0",
               {ram_req, dmem_stall}, dmem_data_out);
    end
    @(posedge clk); #1;
    ram_ack = 1'b0;
    @(negedge clk);
    tests++;
    if (ram_req !== 1'b0 || dmem_data_out !== 32'h0) begin
      fails++;
      $display("FAIL rst_mid_lateack: got %b/%h want 0/0",
               ram_req, dmem_data_out);
    end
    model_out = 32'h0;
    add_vec(1, 0, 12'h3FC, 32'h55AA55AA, 4'b1111, 0, 1, 32'h0,
            10'h0FF, 4'b1111, 32'h55AA55AA, model_out);
    s = st_q.pop_front();
    drive_access(s);
    e = exp_q.pop_front();
    tests++;
    if ({obs_we, obs_addr, obs_be, obs_wdata} !==
        {e.we, e.addr, e.be, e.wdata}) begin
      fails++;
      $display("FAIL rst_mid_store: got %b/%h/%b/%h want %b/%h/%b/%h",
               obs_we, obs_addr, obs_be, obs_wdata,
               e.we, e.addr, e.be, e.wdata);
    end
    tests++;
    if (obs_stall_n != e.stall_n || obs_ld !== e.ld) begin
      fails++;
      $display("FAIL rst_mid_store_tim: got %0d/%h want %0d/%h",
               obs_stall_n, obs_ld, e.stall_n, e.ld);
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_long_ack();
    test_misaligned();
    test_back_to_back();
    test_rst_mid();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
